// File: rtl/vthernet_pkg.sv
// Shared constants and write-FSM encodings for the vthernet receive path.
package vthernet_pkg;
    localparam int OCT          = 8;
    localparam int FCS_LEN      = 4;
    localparam int IPV4_MIN_HDR = 20;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_RECV = 2'd1,
        W_DROP = 2'd2
    } w_state_e;
endpackage

// File: rtl/rx_frame_ram.sv
// Simple dual-port frame buffer: one write port and one registered read port on RX_CLK.
module rx_frame_ram #(
    parameter int DW = 8,
    parameter int AW = 12
) (
    input  logic          RX_CLK,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_dat_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_dat_o
);
    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge RX_CLK) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_dat_i;
        rd_dat_o <= mem_q[rd_addr_i];
    end
endmodule

// File: rtl/rx_frame_ctrl.sv
// Two-slot ping-pong receive buffer: captures IPv4 payload, strips FCS, checks length,
// and hands descriptors to the consumer in arrival order, freeing a slot on acknowledge.
module rx_frame_ctrl
    import vthernet_pkg::*;
#(
    parameter int OCT     = vthernet_pkg::OCT,
    parameter int SLOT_AW = 11,
    parameter int MIN_LEN = IPV4_MIN_HDR
) (
    input  logic               RX_CLK,
    input  logic               rst,
    input  logic               rx_payload_ipv4,
    input  logic [OCT-1:0]     rx_payload,
    input  logic               rx_ethernet_irq,
    input  logic [OCT*6-1:0]   rx_src_mac,
    output logic               desc_valid,
    input  logic               desc_ready,
    output logic               desc_slot,
    output logic [15:0]        desc_len,
    output logic [OCT*6-1:0]   desc_src_mac,
    input  logic [SLOT_AW-1:0] rd_addr,
    output logic [OCT-1:0]     rd_data,
    output logic [15:0]        rx_frame_cnt,
    output logic [15:0]        rx_drop_cnt
);
    localparam logic [16:0] SLOT_BYTES = 17'(1) << SLOT_AW;
    localparam logic [15:0] MIN_CNT    = 16'(MIN_LEN + FCS_LEN);

    w_state_e             state_q, state_d;
    logic                 vld_q;
    logic                 wr_slot_q, wr_slot_d;
    logic                 rd_slot_q, rd_slot_d;
    logic [1:0]           full_q, full_d;
    logic                 gap_q, gap_d;
    logic [15:0]          cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;
    logic [15:0]          len_q [2];
    logic [15:0]          len_d [2];
    logic [OCT*6-1:0]     mac_q [2];
    logic [OCT*6-1:0]     mac_d [2];
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic [15:0]          drop_cnt_q, drop_cnt_d;

    logic                 sof;
    logic                 rel;
    logic                 ram_we;
    logic [SLOT_AW:0]     ram_waddr;

    assign sof          = rx_payload_ipv4 && !vld_q;
    assign desc_valid   = full_q[rd_slot_q] && !gap_q;
    assign rel          = desc_valid && desc_ready;
    assign desc_slot    = rd_slot_q;
    assign desc_len     = len_q[rd_slot_q];
    assign desc_src_mac = mac_q[rd_slot_q];
    assign rx_frame_cnt = frame_cnt_q;
    assign rx_drop_cnt  = drop_cnt_q;

    always_comb begin
        state_d     = state_q;
        wr_slot_d   = wr_slot_q;
        rd_slot_d   = rd_slot_q;
        full_d      = full_q;
        gap_d       = rel;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        len_d       = len_q;
        mac_d       = mac_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        ram_we      = 1'b0;
        ram_waddr   = {wr_slot_q, cnt_q[SLOT_AW-1:0]};

        // Release and commit never target the same slot, so both may land this cycle.
        if (rel) begin
            full_d[rd_slot_q] = 1'b0;
            rd_slot_d         = ~rd_slot_q;
        end

        case (state_q)
            W_IDLE: begin
                if (sof) begin
                    if (!full_q[wr_slot_q]) begin
                        state_d           = W_RECV;
                        mac_d[wr_slot_q]  = rx_src_mac;
                        ram_we            = 1'b1;
                        ram_waddr         = {wr_slot_q, {SLOT_AW{1'b0}}};
                        cnt_d             = 16'd1;
                        ovf_d             = 1'b0;
                    end else begin
                        state_d = W_DROP;
                    end
                end
            end
            W_RECV: begin
                if (rx_ethernet_irq) begin
                    state_d = W_IDLE;
                    if (ovf_q || cnt_q < MIN_CNT) begin
                        drop_cnt_d = drop_cnt_q + 16'd1;
                    end else begin
                        full_d[wr_slot_q] = 1'b1;
                        len_d[wr_slot_q]  = cnt_q - 16'(FCS_LEN);
                        wr_slot_d         = ~wr_slot_q;
                        frame_cnt_d       = frame_cnt_q + 16'd1;
                    end
                end else if (rx_payload_ipv4) begin
                    if ({1'b0, cnt_q} < SLOT_BYTES) ram_we = 1'b1;
                    else                            ovf_d  = 1'b1;
                    if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
                end
            end
            W_DROP: begin
                if (rx_ethernet_irq) begin
                    state_d    = W_IDLE;
                    drop_cnt_d = drop_cnt_q + 16'd1;
                end
            end
            default: state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge RX_CLK) begin
        if (rst) begin
            state_q     <= W_IDLE;
            vld_q       <= 1'b0;
            wr_slot_q   <= 1'b0;
            rd_slot_q   <= 1'b0;
            full_q      <= 2'b00;
            gap_q       <= 1'b0;
            cnt_q       <= 16'd0;
            ovf_q       <= 1'b0;
            len_q[0]    <= 16'd0;
            len_q[1]    <= 16'd0;
            mac_q[0]    <= '0;
            mac_q[1]    <= '0;
            frame_cnt_q <= 16'd0;
            drop_cnt_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            vld_q       <= rx_payload_ipv4;
            wr_slot_q   <= wr_slot_d;
            rd_slot_q   <= rd_slot_d;
            full_q      <= full_d;
            gap_q       <= gap_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            len_q       <= len_d;
            mac_q       <= mac_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    rx_frame_ram #(
        .DW (OCT),
        .AW (SLOT_AW + 1)
    ) u_ram (
        .RX_CLK    (RX_CLK),
        .wr_en_i   (ram_we),
        .wr_addr_i (ram_waddr),
        .wr_dat_i  (rx_payload),
        .rd_addr_i ({rd_slot_q, rd_addr}),
        .rd_dat_o  (rd_data)
    );
endmodule

// File: doc/rx_frame_ctrl.md
# rx_frame_ctrl

Receive-side frame buffer controller between `rx_ethernet` and the IPv4 layer. It captures the IPv4 payload byte stream (`rx_payload_ipv4`/`rx_payload`) into one of two ping-pong slots, strips the trailing 4-byte FCS and validates the length. It commits each good frame as a descriptor on `rx_ethernet_irq`. It then hands descriptors to the consumer in arrival order and frees a slot only when the consumer acknowledges it.

## Interface
Parameters:
- `OCT`, 8, byte width.
- `SLOT_AW`, 11, byte-address width of one slot (2048 bytes per slot).
- `MIN_LEN`, 20, minimum accepted payload length (IPv4 header), FCS excluded.

Ports:
- `RX_CLK`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `rx_payload_ipv4`  in  1  byte-valid from `rx_ethernet`.
- `rx_payload`  in  OCT  payload byte, valid when `rx_payload_ipv4`=1.
- `rx_ethernet_irq`  in  1  one-cycle end-of-frame pulse.
- `rx_src_mac`  in  OCT*6  source MAC of the current frame.
- `desc_valid`  out  1  descriptor available.
- `desc_ready`  in  1  consumer done with the slot; sampled only while `desc_valid`=1.
- `desc_slot`  out  1  slot holding the frame.
- `desc_len`  out  16  payload length in bytes, FCS excluded.
- `desc_src_mac`  out  OCT*6  source MAC of the frame.
- `rd_addr`  in  SLOT_AW  byte offset within `desc_slot`.
- `rd_data`  out  OCT  buffer byte.
- `rx_frame_cnt`  out  16  frames committed; wraps.
- `rx_drop_cnt`  out  16  frames dropped; wraps.

## Operation
Write FSM states: `W_IDLE`, `W_RECV`, `W_DROP`.
- **Start of frame:** the first cycle in which `rx_payload_ipv4` rises from 0 to 1 (tracked with a registered copy).
  - If slot `wr_slot` is free, go to `W_RECV`. Latch `rx_src_mac` into that slot's MAC register. Write the first byte at offset 0 and set `cnt`=1.
  - If the slot is not free, go to `W_DROP`.
- **`W_RECV`:** each valid byte is written to address `{wr_slot, cnt[SLOT_AW-1:0]}`, then `cnt` increments.
  - When `cnt` reaches 2^SLOT_AW, further writes are suppressed and the `ovf` flag is set.
  - `cnt` saturates at 16'hFFFF.
- **`rx_ethernet_irq` in `W_RECV`:** compute `len = cnt - 4`.
  - If `ovf` is set or `cnt < MIN_LEN+4`, the frame is a drop: `rx_drop_cnt`++ and the slot stays free.
  - Otherwise mark `wr_slot` full, store `len`, toggle `wr_slot`, and increment `rx_frame_cnt`.
  - Either way, return to `W_IDLE`.
- **`rx_ethernet_irq` in `W_DROP`:** `rx_drop_cnt`++, return to `W_IDLE`.
- `rx_ethernet_irq` in `W_IDLE` is ignored.
- **Read side:** `rd_slot` points to the oldest full slot.
  - `desc_valid` = `full[rd_slot]` && !`gap`.
  - `desc_valid && desc_ready` clears `full[rd_slot]`, toggles `rd_slot`, and sets `gap` for one cycle.
- **Simultaneous commit and release:** both take effect in the same cycle. The two slots are never the same slot, because the write side only uses a free slot.
- Consumer reads `rd_data` at `{desc_slot, rd_addr}`.
  - Offsets ≥ `desc_len` return don't-care data.
  - The slot is not overwritten until it is released.

## Timing
- Reset values:
  - Outputs: `desc_valid`=0, `desc_slot`=0, `desc_len`=0, `desc_src_mac`=0, `rx_frame_cnt`=0, `rx_drop_cnt`=0.
  - Internal state: both slots free, `wr_slot`=`rd_slot`=0, FSM in `W_IDLE`.
  - `rd_data` is don't-care.
- Reset mid-frame aborts the frame with no count change; the next rising valid starts a new frame.
- Byte write: same cycle the byte is valid (registered RAM write).
- Commit to descriptor: `desc_valid` rises on the cycle after the `rx_ethernet_irq` cycle.
- Descriptor fields are registered and stable for as long as `desc_valid`=1.
- Release: `desc_valid` is 0 in the cycle after the handshake. If the other slot is full, `desc_valid`=1 with the new descriptor one cycle later.
- `rd_data`: one-cycle synchronous read latency from `rd_addr`.
- Back-to-back frames: the minimum gap from `rx_ethernet` is absorbed. Start detection needs only a 0→1 edge.

## Structure
- Shared package `vthernet_pkg`: `OCT`, FCS length (4), IPv4 minimum header length (20), write-FSM state encodings.
- Sub-module `rx_frame_ram`: simple dual-port RAM, 2^(SLOT_AW+1) × OCT, one write port, one synchronous read port, both on `RX_CLK`.
- Everything else, including slot flags, counters, FSM and descriptor registers, lives in `rx_frame_ctrl`.

## Test plan
- **Single good frame:** 64 valid bytes 0x00..0x3F, irq, MAC 02:00:00:00:00:01 → `desc_valid` one cycle after irq; `desc_len`=60; `desc_src_mac`=0x020000000001; `rd_data` at offset k = k for k<60; `rx_frame_cnt`=1.
- **Slot exhaustion:** three 64-byte frames with no `desc_ready` → first two committed to slots 0 and 1; third dropped; `rx_drop_cnt`=1; after two releases the descriptors come out in order, 0 then 1.
- **Runt and oversize:** a 23-byte frame → drop. With `SLOT_AW`=6, a 70-byte frame → drop (`ovf`). No descriptor for either; `rx_drop_cnt`=2.
- **Simultaneous events:** `desc_ready` asserted in the same cycle as the irq of the next frame → slot freed and new frame committed; `rx_frame_cnt` correct; next descriptor after the one-cycle gap.
- **Reset mid-frame:** `rst` after 10 bytes → all outputs reset. The next 64-byte frame lands in slot 0 with `desc_len`=60.
- **Ignored stimulus:** irq pulse with no preceding valid bytes → no count change.
